// File: rtl/float_stream_bridge.sv
// float_stream_bridge: queues A/B/C operand triples to an AXI-Stream FMA IP and returns its results
module float_stream_bridge #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int OUT_W = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            float_a_valid,
   input  logic [XLEN-1:0] float_a_data,
   input  logic            float_b_valid,
   input  logic [XLEN-1:0] float_b_data,
   input  logic [XLEN-1:0] float_c_data,
   output logic            float_result_valid,
   output logic [XLEN-1:0] float_result,
   output logic            m_axis_a_tvalid,
   input  logic            m_axis_a_tready,
   output logic [XLEN-1:0] m_axis_a_tdata,
   output logic            m_axis_b_tvalid,
   input  logic            m_axis_b_tready,
   output logic [XLEN-1:0] m_axis_b_tdata,
   output logic            m_axis_c_tvalid,
   input  logic            m_axis_c_tready,
   output logic [XLEN-1:0] m_axis_c_tdata,
   input  logic            s_axis_r_tvalid,
   output logic            s_axis_r_tready,
   input  logic [XLEN-1:0] s_axis_r_tdata,
   input  logic            err_clear_i,
   output logic            busy_o,
   output logic [2:0]      err_o
);
   localparam int AW = $clog2(DEPTH);
   logic [3*XLEN-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count, count_nx;
   logic [2:0]        taken, hs, err_set;
   logic [OUT_W-1:0]  outstanding, out_nx;
   logic              push, pop, empty, full, r_hs;

   assign empty           = count == '0;
   assign full            = count == (AW+1)'(DEPTH);
   assign m_axis_a_tvalid = !empty && !taken[0];
   assign m_axis_b_tvalid = !empty && !taken[1];
   assign m_axis_c_tvalid = !empty && !taken[2];
   assign hs   = {m_axis_c_tvalid & m_axis_c_tready, m_axis_b_tvalid & m_axis_b_tready, m_axis_a_tvalid & m_axis_a_tready};
   assign pop  = !empty && (&(taken | hs));
   assign push = float_a_valid && float_b_valid && (!full || pop);
   assign r_hs = s_axis_r_tvalid && s_axis_r_tready;
   assign {m_axis_c_tdata, m_axis_b_tdata, m_axis_a_tdata} = mem[rd_ptr];

   // next occupancy, saturating in-flight count and error events for this cycle
   always_comb begin
      count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
      out_nx   = (pop && !r_hs && outstanding != '1) ? outstanding + OUT_W'(1) :
                 (r_hs && !pop && outstanding != '0) ? outstanding - OUT_W'(1) : outstanding;
      err_set  = {r_hs && outstanding == '0, float_a_valid && float_b_valid && full && !pop, float_a_valid ^ float_b_valid};
   end

   // operand storage; contents need no reset since occupancy is tracked separately
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= {float_c_data, float_b_data, float_a_data};
   end

   // control state, result return and sticky error flags
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         taken              <= '0;
         outstanding        <= '0;
         err_o              <= '0;
         s_axis_r_tready    <= 1'b0;
         float_result_valid <= 1'b0;
         float_result       <= '0;
         busy_o             <= 1'b0;
      end else begin
         wr_ptr             <= wr_ptr + AW'(push);
         rd_ptr             <= rd_ptr + AW'(pop);
         count              <= count_nx;
         taken              <= pop ? '0 : taken | hs;
         outstanding        <= out_nx;
         err_o              <= (err_clear_i ? 3'b000 : err_o) | err_set;
         s_axis_r_tready    <= 1'b1;
         float_result_valid <= r_hs;
         if (r_hs) float_result <= s_axis_r_tdata;
         busy_o             <= count_nx != '0 || out_nx != '0;
      end
   end
endmodule

// File: tb/tb_float_stream_bridge.sv
// tb_float_stream_bridge: scoreboard bench for float_stream_bridge with directed vectors
module tb_float_stream_bridge;
   localparam int XLEN = 32;
   logic            clk_i = 1'b0, rst_ni = 1'b0;
   logic            float_a_valid = 0, float_b_valid = 0, err_clear_i = 0;
   logic [XLEN-1:0] float_a_data = '0, float_b_data = '0, float_c_data = '0;
   logic            float_result_valid;
   logic [XLEN-1:0] float_result;
   logic            m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid;
   logic            m_axis_a_tready = 0, m_axis_b_tready = 0, m_axis_c_tready = 0;
   logic [XLEN-1:0] m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata;
   logic            s_axis_r_tvalid = 0, s_axis_r_tready;
   logic [XLEN-1:0] s_axis_r_tdata = '0;
   logic            busy_o;
   logic [2:0]      err_o;
   int              total = 0, bad = 0, na = 0, na0;
   logic [XLEN-1:0] qa[$], qb[$], qc[$], qr[$];

   float_stream_bridge #(.XLEN(XLEN), .DEPTH(4), .OUT_W(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .float_a_valid(float_a_valid), .float_a_data(float_a_data),
      .float_b_valid(float_b_valid), .float_b_data(float_b_data),
      .float_c_data(float_c_data),
      .float_result_valid(float_result_valid), .float_result(float_result),
      .m_axis_a_tvalid(m_axis_a_tvalid), .m_axis_a_tready(m_axis_a_tready), .m_axis_a_tdata(m_axis_a_tdata),
      .m_axis_b_tvalid(m_axis_b_tvalid), .m_axis_b_tready(m_axis_b_tready), .m_axis_b_tdata(m_axis_b_tdata),
      .m_axis_c_tvalid(m_axis_c_tvalid), .m_axis_c_tready(m_axis_c_tready), .m_axis_c_tdata(m_axis_c_tdata),
      .s_axis_r_tvalid(s_axis_r_tvalid), .s_axis_r_tready(s_axis_r_tready), .s_axis_r_tdata(s_axis_r_tdata),
      .err_clear_i(err_clear_i), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input bit exp);
      float_a_valid = 1; float_b_valid = 1;
      float_a_data = a; float_b_data = b; float_c_data = c;
      if (exp) begin qa.push_back(a); qb.push_back(b); qc.push_back(c); end
      tick();
      float_a_valid = 0; float_b_valid = 0;
   endtask

   task automatic result(input logic [31:0] r);
      s_axis_r_tvalid = 1; s_axis_r_tdata = r;
      qr.push_back(r);
      tick();
      s_axis_r_tvalid = 0;
   endtask

   task automatic set_ready(input logic v);
      m_axis_a_tready = v; m_axis_b_tready = v; m_axis_c_tready = v;
   endtask

   // monitor: every handshake and result pulse is matched against the scoreboard
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (m_axis_a_tvalid && m_axis_a_tready) begin
            na++;
            chk("a_avail", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) chk("a_data", m_axis_a_tdata, qa.pop_front());
         end
         if (m_axis_b_tvalid && m_axis_b_tready) begin
            chk("b_avail", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) chk("b_data", m_axis_b_tdata, qb.pop_front());
         end
         if (m_axis_c_tvalid && m_axis_c_tready) begin
            chk("c_avail", 32'(qc.size() > 0), 1);
            if (qc.size() > 0) chk("c_data", m_axis_c_tdata, qc.pop_front());
         end
         if (float_result_valid) begin
            chk("r_avail", 32'(qr.size() > 0), 1);
            if (qr.size() > 0) chk("r_data", float_result, qr.pop_front());
         end
      end
   end

   initial begin
      #12;
      chk("rst_tvalid", {m_axis_c_tvalid, m_axis_b_tvalid, m_axis_a_tvalid}, 0);
      chk("rst_tready", s_axis_r_tready, 0);
      chk("rst_frv", float_result_valid, 0);
      chk("rst_fr", float_result, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      rst_ni = 1;
      tick();
      chk("tready_up", s_axis_r_tready, 1);
      // single triple, all readys high
      set_ready(1);
      push(32'h3F800000, 32'h40000000, 32'h40400000, 1);
      chk("t1_tvalid", {m_axis_c_tvalid, m_axis_b_tvalid, m_axis_a_tvalid}, 3'b111);
      chk("t1_busy", busy_o, 1);
      tick();
      chk("t1_popped", {m_axis_c_tvalid, m_axis_b_tvalid, m_axis_a_tvalid}, 0);
      chk("t1_busy_out", busy_o, 1);
      result(32'h40A00000);
      chk("t1_frv", float_result_valid, 1);
      chk("t1_busy_idle", busy_o, 0);
      tick();
      chk("t1_frv_pulse", float_result_valid, 0);
      chk("t1_fr_hold", float_result, 32'h40A00000);
      // staggered readys
      set_ready(0);
      push(32'h11111111, 32'h22222222, 32'h33333333, 1);
      m_axis_a_tready = 1;
      tick();
      m_axis_a_tready = 0;
      chk("t2_after_a", {m_axis_c_tvalid, m_axis_b_tvalid, m_axis_a_tvalid}, 3'b110);
      chk("t2_b_stable", m_axis_b_tdata, 32'h22222222);
      tick();
      m_axis_b_tready = 1;
      tick();
      m_axis_b_tready = 0;
      chk("t2_after_b", {m_axis_c_tvalid, m_axis_b_tvalid, m_axis_a_tvalid}, 3'b100);
      chk("t2_c_stable", m_axis_c_tdata, 32'h33333333);
      tick();
      m_axis_c_tready = 1;
      chk("t2_c_wait", m_axis_c_tvalid, 1);
      tick();
      m_axis_c_tready = 0;
      chk("t2_popped", {m_axis_c_tvalid, m_axis_b_tvalid, m_axis_a_tvalid}, 0);
      result(32'h44444444);
      chk("t2_busy_idle", busy_o, 0);
      // overflow: five pushes into a four-deep FIFO
      for (int i = 0; i < 5; i++) push(32'hA0 + i, 32'hB0 + i, 32'hC0 + i, i < 4);
      chk("t3_err", err_o, 3'b010);
      chk("t3_busy", busy_o, 1);
      na0 = na;
      set_ready(1);
      repeat (4) tick();
      chk("t3_issued", na - na0, 4);
      chk("t3_drained", {m_axis_c_tvalid, m_axis_b_tvalid, m_axis_a_tvalid}, 0);
      for (int i = 0; i < 4; i++) result(32'h5000 + i);
      err_clear_i = 1;
      tick();
      err_clear_i = 0;
      chk("t3_clear", err_o, 0);
      // back-to-back throughput
      na0 = na;
      for (int i = 0; i < 3; i++) push(32'h100 + i, 32'h200 + i, 32'h300 + i, 1);
      tick();
      chk("tp_issued", na - na0, 3);
      chk("tp_drained", m_axis_a_tvalid, 0);
      for (int i = 0; i < 3; i++) result(32'h6000 + i);
      chk("tp_busy_idle", busy_o, 0);
      // unpaired operand, clear collision, clear
      float_a_valid = 1;
      tick();
      float_a_valid = 0;
      chk("t4_err", err_o, 3'b001);
      chk("t4_nopush", m_axis_a_tvalid, 0);
      chk("t4_busy", busy_o, 0);
      err_clear_i = 1; float_b_valid = 1;
      tick();
      err_clear_i = 0; float_b_valid = 0;
      chk("t4_set_wins", err_o, 3'b001);
      err_clear_i = 1;
      tick();
      err_clear_i = 0;
      chk("t4_cleared", err_o, 0);
      // unexpected result, then reset mid-queue
      result(32'h55555555);
      chk("t5_frv", float_result_valid, 1);
      chk("t5_err", err_o, 3'b100);
      chk("t5_busy", busy_o, 0);
      set_ready(0);
      for (int i = 0; i < 3; i++) push(32'h700 + i, 32'h800 + i, 32'h900 + i, 0);
      chk("t5_queued", m_axis_a_tvalid, 1);
      chk("t5_busy_q", busy_o, 1);
      #2 rst_ni = 0;
      #1;
      chk("t5_rst_tvalid", {m_axis_c_tvalid, m_axis_b_tvalid, m_axis_a_tvalid}, 0);
      chk("t5_rst_busy", busy_o, 0);
      chk("t5_rst_tready", s_axis_r_tready, 0);
      chk("t5_rst_err", err_o, 0);
      chk("t5_rst_fr", float_result, 0);
      #10 rst_ni = 1;
      tick();
      tick();
      chk("t5_empty", {m_axis_c_tvalid, m_axis_b_tvalid, m_axis_a_tvalid}, 0);
      chk("t5_tready", s_axis_r_tready, 1);
      chk("sb_a_left", qa.size(), 0);
      chk("sb_r_left", qr.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/float_stream_bridge.md
# float_stream_bridge

Sits between the MMIO-to-float adapter and the floating-point fused multiply-add IP (AXI4-Stream, operands A, B, C, result R). Captures each operand pulse pair from the adapter together with the current accumulator value, queues the triples in a small FIFO, and issues them over three AXI-Stream channels with full valid/ready handshaking. Returns each IP result to the adapter as a one-cycle result pulse, tracks in-flight operations, and flags protocol errors.

## Interface
Parameters:
- XLEN, 32, operand/result width
- DEPTH, 4, operand FIFO entries (power of two, ≥2)
- OUT_W, 8, width of outstanding-operation counter

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- float_a_valid  in  1  operand A pulse from adapter
- float_a_data  in  XLEN  operand A
- float_b_valid  in  1  operand B pulse from adapter
- float_b_data  in  XLEN  operand B
- float_c_data  in  XLEN  accumulator operand, sampled with A/B
- float_result_valid  out  1  one-cycle result pulse to adapter
- float_result  out  XLEN  result value, held until next pulse
- m_axis_a_tvalid / m_axis_a_tready / m_axis_a_tdata  out/in/out  1/1/XLEN  A channel to IP
- m_axis_b_tvalid / m_axis_b_tready / m_axis_b_tdata  out/in/out  1/1/XLEN  B channel
- m_axis_c_tvalid / m_axis_c_tready / m_axis_c_tdata  out/in/out  1/1/XLEN  C channel
- s_axis_r_tvalid  in  1  result valid from IP
- s_axis_r_tready  out  1  result ready to IP
- s_axis_r_tdata  in  XLEN  result from IP
- err_clear_i  in  1  clears sticky error flags
- busy_o  out  1  FIFO non-empty or outstanding ≠ 0
- err_o  out  3  sticky {unexpected_result, fifo_overflow, unpaired_operand}

## Operation
- Push: cycle with float_a_valid & float_b_valid writes {a, b, c} (c = float_c_data that cycle) into FIFO.
- Exactly one of a/b valid: no push, set err_o[0].
- Push when FIFO full and no pop this cycle: triple dropped, set err_o[1]. Full with pop same cycle: push accepted, count unchanged.
- Issue: FIFO head drives all three tdata; all three tvalid asserted while FIFO non-empty and head not yet fully taken.
- Per-channel "taken" bit set on that channel's tvalid&tready; that channel's tvalid drops next cycle while others wait. tvalid never deasserts before its handshake; tdata stable while tvalid high.
- Pop when the last pending channel handshakes (all three may handshake in one cycle); taken bits clear, next head presented next cycle.
- Outstanding counter: +1 on pop, −1 on result handshake, unchanged if both same cycle; saturates at 2^OUT_W−1 (no wrap).
- s_axis_r_tready = 1 whenever out of reset.
- Result handshake: float_result <= tdata, float_result_valid pulses. If outstanding = 0: still forwarded, set err_o[2], counter stays 0.
- err_clear_i clears err_o; a simultaneous setting event wins.

## Timing
- Reset (rst_ni low, async): FIFO empty, taken bits 0, all tvalid 0, s_axis_r_tready 0, float_result_valid 0, float_result 0, outstanding 0, busy_o 0, err_o 0. Reset mid-operation discards queued and in-flight triples; tready rises on first clock edge after release.
- Push latency: valid pair at cycle N → tvalids high at N+1 (FIFO previously empty).
- Back-to-back: with all treadys high, one triple issued per cycle; pop at N+1 allows next head at N+2 only if already queued; sustained throughput 1/cycle.
- Result latency: handshake at cycle M → float_result_valid high for cycle M+1 only, float_result valid from M+1 onward.
- busy_o registered; reflects state after each edge.

## Test plan
- Reset then single push a=0x3F800000, b=0x40000000, c=0x40400000, treadys high → tdatas match at N+1, pop at N+1, outstanding=1; inject result 0x40A00000 → float_result_valid one cycle, float_result=0x40A00000, busy_o 0.
- Staggered treadys: A ready at N+1, B N+3, C N+5 → each tvalid drops after its own handshake, tdata stable, pop only at N+5.
- Five pushes with all treadys low (DEPTH=4) → four queued, fifth dropped, err_o=3'b010; release readys → exactly four triples issued in order.
- float_a_valid alone → no push, err_o[0]=1; err_clear_i pulse → err_o=0.
- Result with outstanding=0 → forwarded, err_o[2]=1; assert rst_ni low mid-queue with 3 entries → all tvalid 0 immediately, busy_o 0.
